// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM encoding, frame-length floor and majority-vote offsets
// for the configurable UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE,
        BRK_WAIT
    } rx_state_t;

    localparam logic [3:0] DATA_LEN_MIN = 4'd5;

    // Vote window sits around mid-bit: half-1, half, half+1.
    // The majority result is stable two cycles after mid-bit.
    localparam int SMP_OFS_PRE   = 1;
    localparam int SMP_OFS_POST  = 1;
    localparam int SMP_OFS_VALID = 2;

    // Force an out-of-range frame length onto the nearest legal value.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
        if (len < DATA_LEN_MIN)
            return DATA_LEN_MIN;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter, bit counter and 3-sample majority vote.
// clr restarts both counters (state entry); run lets them advance.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  run,
    input  logic                  clr,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  sampled_bit,
    output logic                  sample_done
);

    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last;
    logic [2:0]            smp;

    assign half = prescale >> 1;
    assign last = prescale - PRESCALE_W'(1);

    // Edge counter wraps once per bit time and bumps the bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (run) begin
            if (edge_cnt == last) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end
        end
    end

    // Capture the line three times around mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp <= '0;
        end else if (run) begin
            if (edge_cnt == half - PRESCALE_W'(SMP_OFS_PRE))  smp[0] <= rx_in;
            if (edge_cnt == half)                             smp[1] <= rx_in;
            if (edge_cnt == half + PRESCALE_W'(SMP_OFS_POST)) smp[2] <= rx_in;
        end
    end

    assign sampled_bit = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign sample_done = run && (edge_cnt >= half + PRESCALE_W'(SMP_OFS_VALID));

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: run-time configurable UART receiver (5..DATA_WIDTH data bits,
// optional even/odd parity, 1 or 2 stop bits, Prescale 8/16/32) with majority
// voting and per-frame configuration latch.
// Define UART_RX_BREAK_DET_EN to add break detection and the break_det port.
module uart_rx_cfg
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [3:0]            DATA_LEN,
    input  logic                  STOP2,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  framing_error,
`ifdef UART_RX_BREAK_DET_EN
    output logic                  break_det,
`endif
    output logic                  busy
);

    rx_state_t             state, state_nxt;
    logic [PRESCALE_W-1:0] pre_q;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [3:0]            len_q;
    logic [3:0]            bit_cnt;
    logic                  par_en_q, par_typ_q, stop2_q;
    logic                  smp_bit, smp_rdy, bit_end;
    logic                  run, clr, start_go, fin;
    logic [DATA_WIDTH-1:0] shadow;
    logic                  par_acc, par_fail, stp_fail, stp_fail_d;
`ifdef UART_RX_BREAK_DET_EN
    logic                  all_zero, all_zero_d;
`endif

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk         (CLK),
        .rst_n       (RST),
        .rx_in       (RX_IN),
        .prescale    (pre_q),
        .run         (run),
        .clr         (clr),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .sampled_bit (smp_bit),
        .sample_done (smp_rdy)
    );

    assign bit_end  = smp_rdy && (edge_cnt == pre_q - PRESCALE_W'(1));
    assign run      = (state != IDLE) && (state != DONE);
    // Counters restart on every state change; while waiting out a break,
    // any low sample restarts the "one full high bit" count.
    assign clr      = (state_nxt != state) || ((state == BRK_WAIT) && !RX_IN);
    assign start_go = (state == IDLE) && !RX_IN;
    assign fin      = (state == STOP) && (state_nxt == DONE);
    assign busy     = (state != IDLE);

    // Stop failure including the sample taken on the final stop-bit edge.
    assign stp_fail_d = stp_fail | ((state == STOP) && bit_end && !smp_bit);
`ifdef UART_RX_BREAK_DET_EN
    assign all_zero_d = all_zero & ~(bit_end & smp_bit);
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (!RX_IN) state_nxt = START;
            START:    if (bit_end) state_nxt = smp_bit ? IDLE : DATA;
            DATA:     if (bit_end && (bit_cnt == len_q - 4'd1))
                          state_nxt = par_en_q ? PARITY : STOP;
            PARITY:   if (bit_end) state_nxt = STOP;
            STOP:     if (bit_end && (!stop2_q || (bit_cnt == 4'd1))) state_nxt = DONE;
`ifdef UART_RX_BREAK_DET_EN
            DONE:     state_nxt = break_det ? BRK_WAIT : IDLE;
            BRK_WAIT: if (bit_end && RX_IN) state_nxt = IDLE;
`else
            DONE:     state_nxt = IDLE;
            BRK_WAIT: state_nxt = IDLE;
`endif
            default:  state_nxt = IDLE;
        endcase
    end

    // Latch the frame format on start detection; mid-frame changes are ignored.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pre_q     <= '0;
            len_q     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else if (start_go) begin
            pre_q     <= Prescale;
            len_q     <= clamp_len(DATA_LEN, 4'(DATA_WIDTH));
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            stop2_q   <= STOP2;
        end
    end

    // Collect data bits LSB-first plus running parity and stop status.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shadow   <= '0;
            par_acc  <= 1'b0;
            par_fail <= 1'b0;
            stp_fail <= 1'b0;
        end else if (start_go) begin
            shadow   <= '0;
            par_acc  <= 1'b0;
            par_fail <= 1'b0;
            stp_fail <= 1'b0;
        end else if (bit_end) begin
            case (state)
                DATA: begin
                    for (int i = 0; i < DATA_WIDTH; i++)
                        if (bit_cnt == 4'(i)) shadow[i] <= smp_bit;
                    par_acc <= par_acc ^ smp_bit;
                end
                PARITY:  par_fail <= ((par_acc ^ par_typ_q) != smp_bit);
                STOP:    if (!smp_bit) stp_fail <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    // Track whether every data, parity and stop sample of the frame was low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            all_zero <= 1'b0;
        else if (start_go)
            all_zero <= 1'b1;
        else if (bit_end && ((state == DATA) || (state == PARITY) || (state == STOP)))
            all_zero <= all_zero & ~smp_bit;
    end
`endif

    // Errors clear on start; results publish as the FSM enters DONE so they
    // are visible during the DONE cycle together with the valid pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA        <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_det     <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_det  <= 1'b0;
`endif
            if (start_go) begin
                parity_error  <= 1'b0;
                framing_error <= 1'b0;
            end else if (fin) begin
                parity_error  <= par_fail;
`ifdef UART_RX_BREAK_DET_EN
                framing_error <= stp_fail_d & ~all_zero_d;
                break_det     <= all_zero_d;
`else
                framing_error <= stp_fail_d;
`endif
                if (!par_fail && !stp_fail_d) begin
                    P_DATA     <= shadow;
                    data_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed plus randomized frames against a frame-level model.
// Each frame pushes its expected outcome; a monitor pops on every busy fall.
module tb_uart_rx_cfg;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic [PW-1:0] pre = 6'd16;
    logic          par_en = 1'b0, par_typ = 1'b0, stop2 = 1'b0;
    logic [3:0]    dlen = 4'd8;
    logic [DW-1:0] p_data;
    logic          dv, perr, ferr, busy;
`ifdef UART_RX_BREAK_DET_EN
    logic          brk;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         nvalid;
        int         nbrk;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] last_good = 8'h00;

    always #5 clk = ~clk;

    uart_rx_cfg #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK           (clk),
        .RST           (rst_n),
        .RX_IN         (rx),
        .Prescale      (pre),
        .PAR_EN        (par_en),
        .PAR_TYP       (par_typ),
        .DATA_LEN      (dlen),
        .STOP2         (stop2),
        .P_DATA        (p_data),
        .data_valid    (dv),
        .parity_error  (perr),
        .framing_error (ferr),
`ifdef UART_RX_BREAK_DET_EN
        .break_det     (brk),
`endif
        .busy          (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: count pulses during a frame, compare on busy falling.
    logic busy_d = 1'b0;
    int   vcnt = 0;
    int   bcnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_d = 1'b0;
            vcnt   = 0;
            bcnt   = 0;
        end else begin
            if (busy && !busy_d) begin
                vcnt = 0;
                bcnt = 0;
            end
            if (dv) vcnt++;
`ifdef UART_RX_BREAK_DET_EN
            if (brk) bcnt++;
`endif
            if (!busy && busy_d) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_pdata"}, int'(p_data), int'(e.data));
                    chk({e.name, "_perr"},  int'(perr),   int'(e.perr));
                    chk({e.name, "_ferr"},  int'(ferr),   int'(e.ferr));
                    chk({e.name, "_nvalid"}, vcnt, e.nvalid);
                    chk({e.name, "_nbrk"},   bcnt, e.nbrk);
                end
            end
            busy_d = busy;
        end
    end

    task automatic hold(input logic b, input int n);
        rx = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int p, input logic spk);
        if (spk) begin
            hold(b, p / 2 + 1);
            hold(~b, 1);
            hold(b, p - p / 2 - 2);
        end else begin
            hold(b, p);
        end
    endtask

    function automatic logic [PW-1:0] rand_pre();
        case ($urandom_range(0, 2))
            0:       return 6'd8;
            1:       return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    // Frame-level reference: clamp length, mask data, derive parity/stop
    // outcome, push expectation, then drive the line bit by bit.
    task automatic send_frame(input string name, input logic [7:0] data, input logic [3:0] len_in,
                              input logic pe, input logic pt, input logic s2, input int p,
                              input logic flip, input logic [1:0] bs, input logic spk);
        int         len;
        logic [7:0] md;
        logic       pbit, sbad, allz;
        exp_t       e;
        len  = (len_in < 4'd5) ? 5 : ((int'(len_in) > DW) ? DW : int'(len_in));
        md   = data & 8'((1 << len) - 1);
        pbit = (^md) ^ pt ^ flip;
        sbad = bs[0] || (s2 && bs[1]);
        allz = (md == 8'h00) && (!pe || !pbit) && bs[0] && (!s2 || bs[1]);
        e.name   = name;
        e.perr   = pe && flip;
        e.ferr   = sbad;
        e.nbrk   = 0;
`ifdef UART_RX_BREAK_DET_EN
        if (allz) begin
            e.ferr = 1'b0;
            e.nbrk = 1;
        end
`endif
        e.nvalid = (!e.perr && !sbad) ? 1 : 0;
        if (e.nvalid == 1) last_good = md;
        e.data = last_good;
        sb.push_back(e);

        pre = 6'(p); par_en = pe; par_typ = pt; stop2 = s2; dlen = len_in;
        hold(1'b0, p);
        // The format was latched at start; scramble the pins for the rest of the frame.
        pre = rand_pre(); par_en = 1'($urandom); par_typ = 1'($urandom);
        stop2 = 1'($urandom); dlen = 4'($urandom_range(0, 15));
        for (int i = 0; i < len; i++) send_bit(md[i], p, spk);
        if (pe) send_bit(pbit, p, spk);
        send_bit(~bs[0], p, spk);
        if (s2) send_bit(~bs[1], p, spk);
        hold(1'b1, allz ? 2 * p + 4 : 2 + $urandom_range(0, 10));
    endtask

    initial begin
        exp_t g;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pdata", int'(p_data), 0);
        chk("rst_valid", int'(dv), 0);
        chk("rst_perr",  int'(perr), 0);
        chk("rst_ferr",  int'(ferr), 0);
        chk("rst_busy",  int'(busy), 0);
        rst_n = 1'b1;
        hold(1'b1, 5);

        send_frame("8n1_a5",        8'hA5, 4'd8, 0, 0, 0, 16, 0, 2'b00, 0);
        send_frame("7e2_35",        8'h35, 4'd7, 1, 0, 1,  8, 0, 2'b00, 0);
        send_frame("7e2_35_badpar", 8'h35, 4'd7, 1, 0, 1,  8, 1, 2'b00, 0);
        send_frame("8n1_badstop",   8'h96, 4'd8, 0, 0, 0, 16, 0, 2'b01, 0);
        send_frame("8n1_3c",        8'h3C, 4'd8, 0, 0, 0, 16, 0, 2'b00, 0);

        // Short low glitch on an idle line: start aborts, nothing changes.
        pre = 6'd16; par_en = 1'b0; stop2 = 1'b0; dlen = 4'd8;
        g.name = "glitch"; g.data = last_good; g.perr = 1'b0; g.ferr = 1'b0;
        g.nvalid = 0; g.nbrk = 0;
        sb.push_back(g);
        hold(1'b0, 4);
        hold(1'b1, 40);

        send_frame("spikes_5a",     8'h5A, 4'd8, 0, 0, 0, 16, 0, 2'b00, 1);
        send_frame("8o1_spk",       8'hC7, 4'd8, 1, 1, 0,  8, 0, 2'b00, 1);

        // Reset in the middle of the data bits, then a clean frame.
        pre = 6'd16; par_en = 1'b0; stop2 = 1'b0; dlen = 4'd8;
        hold(1'b0, 16);
        hold(1'b1, 16);
        hold(1'b0, 8);
        rst_n = 1'b0;
        #1;
        chk("midrst_pdata", int'(p_data), 0);
        chk("midrst_valid", int'(dv), 0);
        chk("midrst_perr",  int'(perr), 0);
        chk("midrst_ferr",  int'(ferr), 0);
        chk("midrst_busy",  int'(busy), 0);
        last_good = 8'h00;
        hold(1'b1, 4);
        rst_n = 1'b1;
        hold(1'b1, 10);
        send_frame("after_rst_81",  8'h81, 4'd8, 0, 0, 0, 16, 0, 2'b00, 0);

        // Out-of-range lengths clamp to 5 and DW.
        send_frame("len3_clamp",    8'hFF, 4'd3,  0, 0, 0, 16, 0, 2'b00, 0);
        send_frame("len15_clamp",   8'hC3, 4'd15, 1, 0, 0,  8, 0, 2'b00, 0);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] bs;
            bs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            send_frame("rand", 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom),
                       1'($urandom), 1'($urandom), int'(rand_pre()),
                       ($urandom_range(0, 3) == 0), bs, 1'($urandom));
        end

`ifdef UART_RX_BREAK_DET_EN
        // Line held low for 20 bit times: one break pulse, busy until high.
        pre = 6'd16; par_en = 1'b0; stop2 = 1'b0; dlen = 4'd8;
        g.name = "break"; g.data = last_good; g.perr = 1'b0; g.ferr = 1'b0;
        g.nvalid = 0; g.nbrk = 1;
        sb.push_back(g);
        hold(1'b0, 20 * 16);
        chk("break_busy_low_line", int'(busy), 1);
        hold(1'b1, 40);
`endif

        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
        chk("sb_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Second-generation UART receiver with the frame format configurable at run time: data length 5..DATA_WIDTH, optional parity (even/odd), 1 or 2 stop bits, and oversampling Prescale.
- Adds 3-sample majority voting, per-frame latching of the configuration, and a busy flag.
- Sits between the pad-side RX line and the system register/FIFO interface, in the same clock domain as the oversampling clock.

Parameters:
- DATA_WIDTH, 8, maximum data bits per frame; legal range 5..9.
- PRESCALE_W, 6, width of the Prescale input.

Ports:
- CLK  in  1  oversampling clock; one Prescale period equals one bit time.
- RST  in  1  asynchronous active-low reset.
- RX_IN  in  1  serial line, idle high; already synchronised upstream.
- Prescale  in  PRESCALE_W  clocks per bit; legal values 8, 16, 32.
- PAR_EN  in  1  parity bit present.
- PAR_TYP  in  1  0 = even, 1 = odd.
- DATA_LEN  in  4  data bits per frame, 5..DATA_WIDTH.
- STOP2  in  1  1 = two stop bits.
- P_DATA  out  DATA_WIDTH  last good frame, LSB-aligned; bits at or above DATA_LEN are zero.
- data_valid  out  1  one-cycle pulse when a good frame completes.
- parity_error  out  1  sticky parity error for the last frame.
- framing_error  out  1  sticky stop-bit error for the last frame.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, any state including mid-frame): state IDLE, all counters 0, all outputs 0.
- Configuration latch: PAR_EN, PAR_TYP, DATA_LEN, STOP2 and Prescale are latched on the IDLE->START transition. Changes during a frame are ignored.
- Counters:
  - edge_cnt counts 0..Prescale-1 within each bit, then wraps and increments bit_cnt.
  - bit_cnt resets to 0 on entry to each state.
- Sampling: RX_IN is captured at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1. The sampled bit is the 2-of-3 majority, valid from edge_cnt = Prescale/2+2.
- State machine:
  - IDLE: RX_IN = 0 -> START, edge_cnt = 0. Start detection is level-based, so a line held low restarts framing.
  - START: at edge_cnt = Prescale-1, if the sampled bit = 1 (glitch) -> IDLE with no flags changed; otherwise -> DATA. On entry to START, parity_error and framing_error clear to 0.
  - DATA: shift sampled bits LSB-first into a shadow register. After DATA_LEN bits -> PARITY if PAR_EN, else STOP.
  - PARITY: expected parity = XOR of the received data bits, XOR PAR_TYP. A mismatch sets the internal par_fail flag. -> STOP at end of bit.
  - STOP: a sampled 0 sets the internal stp_fail flag.
    - If STOP2 is set, a second stop bit is checked the same way.
    - At edge_cnt = Prescale-1 of the last stop bit -> DONE.
  - DONE (one cycle):
    - parity_error <= par_fail; framing_error <= stp_fail.
    - If neither flag is set, P_DATA <= shadow (upper bits zeroed) and data_valid = 1.
    - -> IDLE.
- Latency: data_valid occurs 1 cycle after the last stop-bit edge.
- Erroneous frames never update P_DATA and never pulse data_valid.
- A back-to-back start bit is detected in the cycle after DONE.
- An out-of-range DATA_LEN (<5 or >DATA_WIDTH) is clamped to the nearest legal value at latch time.

Optional Feature:
- Macro UART_RX_BREAK_DET_EN.
- Defined:
  - Adds output port break_det (1 bit).
  - If all data, parity and stop samples are 0, DONE pulses break_det for 1 cycle instead of setting framing_error.
  - The FSM then enters BRK_WAIT, holding busy = 1 until RX_IN has sampled 1 for one full bit, then -> IDLE.
- Undefined: the port is absent, a break is reported as framing_error, and the FSM returns to IDLE.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enumeration (IDLE, START, DATA, PARITY, STOP, DONE, BRK_WAIT);
  - the DATA_LEN_MIN = 5 constant;
  - the majority-vote offset constants.
- Sub-module uart_rx_sampler: edge/bit counters plus 3-sample majority vote, exporting edge_cnt, bit_cnt, sampled_bit and sample_done.

Test Plan:
- 8N1, Prescale = 16, byte 0xA5 -> data_valid pulse once, P_DATA = 0xA5, both errors 0, busy low after DONE.
- 7E2, Prescale = 8, data 0x35 with correct even parity, then the same frame with the parity bit flipped -> first: P_DATA = 0x35, valid; second: parity_error = 1, no data_valid, P_DATA still 0x35.
- 8N1 with stop bit driven 0 -> framing_error = 1, no data_valid; next good frame 0x3C clears the error at START and gives valid with P_DATA = 0x3C.
- 4-cycle low glitch on idle line, Prescale = 16 -> return to IDLE, no outputs change; single-cycle mid-bit spikes inside 0x5A are voted out, giving P_DATA = 0x5A.
- RST asserted during DATA of a frame, released, then frame 0x81 -> all outputs 0 during reset, then clean reception of 0x81; DATA_LEN changed mid-frame does not corrupt the frame.
- With UART_RX_BREAK_DET_EN: line held low for 20 bit times -> one break_det pulse, framing_error = 0, busy until the line returns high.
